// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, 32x32 register file with write-through,
// main control decoder, load-use hazard detection and the registered ID/EX bundle.
module id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_fetch_pc,
    input  logic [31:0] i_fetch_instr,
    input  logic        i_flush,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_pcWrite,
    output logic        o_id_valid,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_rs_data,
    output logic [31:0] o_rt_data,
    output logic [31:0] o_imm,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [5:0]  o_funct,
    output logic        o_regwrite,
    output logic        o_memread,
    output logic        o_memwrite,
    output logic        o_memtoreg,
    output logic        o_alusrc,
    output logic        o_regdst,
    output logic        o_branch,
    output logic [1:0]  o_aluop
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        alusrc;
        logic        regdst;
        logic        branch;
        logic [1:0]  aluop;
    } idex_t;

    logic [31:0] ifid_pc_reg;
    logic [31:0] ifid_instr_reg;
    logic        ifid_valid_reg;
    idex_t       idex_reg;
    idex_t       idex_next;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        reads_rt;
    logic        stall;

    assign opcode = ifid_instr_reg[31:26];
    assign rs     = ifid_instr_reg[25:21];
    assign rt     = ifid_instr_reg[20:16];

    // Register file: r0 is hard-wired to zero, r1..r31 are individual reset-able words.
    logic [31:0] rf_word [32];
    assign rf_word[0] = '0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_rf
            logic [31:0] word_reg;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    word_reg <= '0;
                end else if (i_wb_we && i_wb_addr == 5'(gi)) begin
                    word_reg <= i_wb_data;
                end
            end
            assign rf_word[gi] = word_reg;
        end
    endgenerate

    // Same-cycle writeback bypass so the consumer never waits on the register file.
    assign rs_data = (i_wb_we && i_wb_addr == rs && rs != 5'd0) ? i_wb_data : rf_word[rs];
    assign rt_data = (i_wb_we && i_wb_addr == rt && rt != 5'd0) ? i_wb_data : rf_word[rt];

    assign reads_rt  = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    assign stall     = idex_reg.memread && (idex_reg.rt != 5'd0)
                       && ((idex_reg.rt == rs) || (reads_rt && idex_reg.rt == rt))
                       && !i_flush;
    assign o_pcWrite = !stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ifid_pc_reg    <= '0;
            ifid_instr_reg <= NOP_INSTR;
            ifid_valid_reg <= 1'b0;
        end else if (i_flush) begin
            ifid_pc_reg    <= '0;
            ifid_instr_reg <= NOP_INSTR;
            ifid_valid_reg <= 1'b0;
        end else if (!stall) begin
            ifid_pc_reg    <= i_fetch_pc;
            ifid_instr_reg <= i_fetch_instr;
            ifid_valid_reg <= 1'b1;
        end
    end

    always_comb begin
        idex_next = '0;
        if (!(i_flush || stall || !ifid_valid_reg)) begin
            idex_next.valid   = 1'b1;
            idex_next.pc      = ifid_pc_reg;
            idex_next.rs_data = rs_data;
            idex_next.rt_data = rt_data;
            idex_next.imm     = {{16{ifid_instr_reg[15]}}, ifid_instr_reg[15:0]};
            idex_next.rs      = rs;
            idex_next.rt      = rt;
            idex_next.rd      = ifid_instr_reg[15:11];
            idex_next.funct   = ifid_instr_reg[5:0];
            // Unknown opcodes flow through as valid no-ops with all control low.
            case (opcode)
                OP_RTYPE: begin
                    idex_next.regwrite = 1'b1;
                    idex_next.regdst   = 1'b1;
                    idex_next.aluop    = 2'b10;
                end
                OP_LW: begin
                    idex_next.regwrite = 1'b1;
                    idex_next.memread  = 1'b1;
                    idex_next.memtoreg = 1'b1;
                    idex_next.alusrc   = 1'b1;
                end
                OP_SW: begin
                    idex_next.memwrite = 1'b1;
                    idex_next.alusrc   = 1'b1;
                end
                OP_BEQ: begin
                    idex_next.branch = 1'b1;
                    idex_next.aluop  = 2'b01;
                end
                OP_ADDI: begin
                    idex_next.regwrite = 1'b1;
                    idex_next.alusrc   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idex_reg <= '0;
        end else begin
            idex_reg <= idex_next;
        end
    end

    assign o_id_valid = idex_reg.valid;
    assign o_id_pc    = idex_reg.pc;
    assign o_rs_data  = idex_reg.rs_data;
    assign o_rt_data  = idex_reg.rt_data;
    assign o_imm      = idex_reg.imm;
    assign o_rs       = idex_reg.rs;
    assign o_rt       = idex_reg.rt;
    assign o_rd       = idex_reg.rd;
    assign o_funct    = idex_reg.funct;
    assign o_regwrite = idex_reg.regwrite;
    assign o_memread  = idex_reg.memread;
    assign o_memwrite = idex_reg.memwrite;
    assign o_memtoreg = idex_reg.memtoreg;
    assign o_alusrc   = idex_reg.alusrc;
    assign o_regdst   = idex_reg.regdst;
    assign o_branch   = idex_reg.branch;
    assign o_aluop    = idex_reg.aluop;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of fetch.
- Holds the IF/ID pipeline register, the 32x32 register file with write-through, the main control decoder and load-use hazard detection.
- Drives the fetch stage's PC-write enable and produces the registered ID/EX bundle for execute.
- PCs are word addresses; fetch increments by 1.

Parameters:
NOP_INSTR, 32'h0000_0000, instruction loaded into IF/ID on reset/flush (sll r0,r0,0).

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous reset, active low
i_fetch_pc  in  32  PC of fetched instruction
i_fetch_instr  in  32  fetched instruction
i_flush  in  1  taken branch from execute; squash IF/ID and ID/EX
i_wb_we  in  1  writeback register write enable
i_wb_addr  in  5  writeback destination register
i_wb_data  in  32  writeback data
o_pcWrite  out  1  PC/IF-ID update enable to fetch; 0 = stall
o_id_valid  out  1  ID/EX holds a real instruction
o_id_pc  out  32  ID/EX PC
o_rs_data  out  32  ID/EX rs operand
o_rt_data  out  32  ID/EX rt operand
o_imm  out  32  ID/EX sign-extended instr[15:0]
o_rs, o_rt, o_rd  out  5 each  ID/EX register numbers
o_funct  out  6  ID/EX instr[5:0]
o_regwrite, o_memread, o_memwrite, o_memtoreg, o_alusrc, o_regdst, o_branch  out  1 each  ID/EX control
o_aluop  out  2  00 add, 01 sub, 10 use funct

Behaviour:
- Reset (async, i_rst_n=0):
  - IF/ID instr = NOP_INSTR, IF/ID pc = 0, IF/ID valid = 0.
  - All ID/EX outputs = 0.
  - All 32 registers = 0.
  - o_pcWrite = 1.
  - Reset mid-stall or mid-flush aborts immediately; the first post-reset cycle is bubble-only.
- IF/ID register, on rising edge, priority order:
  1. i_flush: load NOP, valid=0.
  2. Stall: hold.
  3. Otherwise: capture i_fetch_pc, i_fetch_instr, valid=1.
- Decode is combinational from IF/ID:
  - opcode=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm sign-extended from [15:0].
  - R-type 0x00: regwrite, regdst, aluop=10.
  - lw 0x23: regwrite, memread, memtoreg, alusrc, aluop=00.
  - sw 0x2B: memwrite, alusrc, aluop=00.
  - beq 0x04: branch, aluop=01.
  - addi 0x08: regwrite, alusrc, aluop=00.
  - Any other opcode: all control 0 (treated as NOP, valid still propagates).
- Register file:
  - r0 reads 0 always; writes to r0 ignored.
  - Write on rising edge when i_wb_we=1 and i_wb_addr!=0.
  - Reads combinational with write-through: if i_wb_we && i_wb_addr==read addr && addr!=0, return i_wb_data in the same cycle.
- Load-use hazard: stall = ID/EX memread && ID/EX rt!=0 && (ID/EX rt==IF/ID rs || (ID/EX rt==IF/ID rt && opcode in {R-type, sw, beq})) && !i_flush.
  - o_pcWrite = !stall, combinational.
- ID/EX register, on rising edge, priority order:
  1. i_flush or stall or IF/ID valid=0: load bubble (all control 0, valid=0, data fields 0).
  2. Otherwise: capture decoded fields, operands and pc, valid=1.
- Latency: fetch output to ID/EX outputs is 2 edges with no stall; a stall adds exactly 1 bubble cycle.
- Flush and stall in the same cycle: flush wins, o_pcWrite=1.
- Writeback to the register being read in the same cycle is seen via bypass; no extra stall.

Test Plan:
- Straight-line: addi r1,r0,5 (0x20010005) at pc 0 -> two edges later o_regwrite=1, o_alusrc=1, o_imm=5, o_rt=1, o_id_pc=0, o_id_valid=1.
- Load-use: lw r2,0(r1) then add r3,r2,r1 -> o_pcWrite=0 for exactly 1 cycle, ID/EX shows one bubble (valid=0), then add issues with o_rs=2, o_rt=1.
- Load to r0: lw r0,0(r1) then add r3,r0,r1 -> no stall, o_pcWrite stays 1.
- Write-through: i_wb_we=1, i_wb_addr=4, i_wb_data=0xDEADBEEF while IF/ID holds add r5,r4,r4 -> o_rs_data=o_rt_data=0xDEADBEEF next edge; write to r0 with 0x1234 -> r0 still reads 0.
- Flush during stall: i_flush=1 in a load-use stall cycle -> o_pcWrite=1, next edge IF/ID=NOP and ID/EX bubble, o_id_valid=0.
- Async reset mid-stream: drop i_rst_n between edges -> all outputs 0 immediately, o_pcWrite=1, previously written registers read 0.
